writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
Completion end of the issue/scoreboard protocol. Accepts finished results from the three functional units (ALU, MEM, MUL) and buffers one result per unit. Arbitrates the single register-file write port round-robin. For every retired instruction it pulses the scoreboard clear interface, so the pending bit set at issue is released. Sits between the execute units and the register file / scoreboard.

Parameters:
DATA_W, 32, result data width
REG_AW, 5, register address width
CNT_W, 32, retired-instruction counter width

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
fu_wb_valid  input  3  per-unit result valid; bit0 ALU, bit1 MEM, bit2 MUL
fu_wb_ready  output  3  per-unit holding slot can accept
fu_wb_regdest  input  3*REG_AW  per-unit destination register, unit i at [i*5+:5]
fu_wb_data  input  3*DATA_W  per-unit result, unit i at [i*32+:32]
fu_wb_writereg  input  3  per-unit instruction writes a register
fu_wb_ov  input  3  per-unit overflow occurred
fu_wb_writeov  input  3  per-unit write permitted on overflow
wb_reg_addr  output  REG_AW  register-file write address
wb_reg_data  output  DATA_W  register-file write data
wb_reg_we  output  1  register-file write enable, one-cycle pulse
wb_sb_clr  output  1  scoreboard clear pulse
wb_sb_clr_addr  output  REG_AW  register whose pending bit is cleared
wb_sb_clr_fu  output  2  unit code of the retiring instruction: 01 ALU, 10 MEM, 11 MUL
wb_retired_count  output  CNT_W  count of granted entries since reset

Behaviour:
- Reset is asynchronous, active-low, and takes effect mid-operation:
  - all holding slots empty
  - round-robin pointer = 0 (ALU)
  - wb_reg_we = 0, wb_sb_clr = 0
  - wb_reg_addr, wb_reg_data, wb_sb_clr_addr, wb_sb_clr_fu = 0
  - wb_retired_count = 0
  - any buffered entries are discarded with no write or clear pulse.
- Holding slot i captures regdest, data, writereg, ov and writeov on a rising edge when fu_wb_valid[i] && fu_wb_ready[i].
- fu_wb_ready[i] = !full[i] || grant[i] (combinational). This allows back-to-back acceptance: 1 result/cycle per unit when uncontended.
- Arbiter (combinational):
  - among full slots, grant the first at or after the pointer, wrapping 2 to 0
  - at most one grant per cycle
  - on a grant to unit g, the pointer becomes (g+1) mod 3 at the edge; with no grant the pointer holds.
- Output stage (registered), at the edge ending a cycle with a grant to unit g:
  - wb_reg_addr = regdest, wb_reg_data = data
  - wb_reg_we = writereg && (regdest != 0) && !(ov && !writeov)
  - wb_sb_clr = writereg
  - wb_sb_clr_addr = regdest
  - wb_sb_clr_fu = g+1
  - wb_retired_count increments, wrapping modulo 2^CNT_W.
- Clear is issued even when the write is suppressed (overflow or r0), which avoids a scoreboard deadlock.
- With no grant, wb_reg_we = 0 and wb_sb_clr = 0; address and data hold their last values.
- Latency: valid accepted at edge E, uncontended → write/clear pulses visible in the cycle after edge E+1.
- Granted slot with simultaneous new valid: the slot is freed and reloaded at the same edge (ready = 1).
- The slot contents are stable while full; upstream holds valid/data while ready = 0.

Decomposition:
- Package wb_pkg holds:
  - FU codes: FU_NONE 2'b00, FU_ALU 2'b01, FU_MEM 2'b10, FU_MUL 2'b11
  - FU index constants 0..2, NUM_FU = 3, REG_AW, DATA_W
  - the holding-slot record type.
- Sub-module rr_arbiter3 takes request[2:0] and ptr[1:0] and produces a one-hot grant[2:0] plus the encoded grant index. It is purely combinational; the pointer register stays in the parent.

Test Plan:
- ALU valid, regdest 5, data 0x00001234, writereg 1, ov 0 → one cycle later: we = 1, addr 5, data 0x00001234, clr = 1, clr_addr 5, clr_fu 01, count 1.
- ALU, MEM and MUL all valid in the same cycle, pointer 0 → writes on 3 consecutive cycles in order ALU, MEM, MUL; MEM/MUL ready low until granted; pointer ends at 0.
- MUL result with ov 1, writeov 0, regdest 9 → we = 0, clr = 1, clr_addr 9, clr_fu 11, count increments.
- ALU result with regdest 0, writereg 1 → we = 0, clr = 1, clr_addr 0.
- ALU valid on 4 consecutive cycles, other units idle → 4 consecutive we pulses, ready stays 1 throughout.
- MEM entry buffered and blocked behind a full ALU slot, then reset asserted low → all outputs 0 asynchronously; after release ready = 3'b111, no we/clr pulse, count 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: functional-unit codes and
// indices, default widths, and the per-unit holding-slot record.
package wb_pkg;

    // Number of functional units feeding the writeback port
    localparam int NUM_FU = 3;

    // Index of each unit in the fu_wb_* port vectors
    localparam int FU_IDX_ALU = 0;
    localparam int FU_IDX_MEM = 1;
    localparam int FU_IDX_MUL = 2;

    // Default widths of the register address and result data
    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    // Unit code reported to the scoreboard on retirement
    typedef enum logic [1:0] {
        FU_NONE = 2'b00,
        FU_ALU  = 2'b01,
        FU_MEM  = 2'b10,
        FU_MUL  = 2'b11
    } fu_code_t;

    // One buffered result waiting for the register-file write port
    typedef struct packed {
        logic [REG_AW-1:0] regdest;
        logic [DATA_W-1:0] data;
        logic              writereg;
        logic              ov;
        logic              writeov;
    } slot_t;

    // Map a unit index to the code the scoreboard expects (index + 1)
    function automatic fu_code_t fu_code_of(input logic [1:0] idx);
        fu_code_t code;
        case (idx)
            2'd0:    code = FU_ALU;
            2'd1:    code = FU_MEM;
            2'd2:    code = FU_MUL;
            default: code = FU_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin grant selection. Purely combinational: the caller
// owns the pointer register and advances it past the granted requester.
module rr_arbiter3
(
    input  logic [2:0] request,
    input  logic [1:0] ptr,
    output logic [2:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_any
);
    import wb_pkg::*;

    logic [1:0] base;
    logic [1:0] idx;

    // Scan requesters starting at the pointer, wrapping 2 -> 0; first hit wins
    always_comb begin
        grant     = 3'b000;
        grant_idx = 2'd0;
        grant_any = 1'b0;
        idx       = 2'd0;
        // A pointer value of 3 is unreachable; treat it as ALU to stay safe
        base      = (ptr == 2'd3) ? 2'd0 : ptr;
        for (int k = 0; k < NUM_FU; k++) begin
            case (base)
                2'd0:    idx = 2'(k);
                2'd1:    idx = (k == 2) ? 2'd0 : 2'(k + 1);
                default: idx = (k == 0) ? 2'd2 : 2'(k - 1);
            endcase
            if (!grant_any && request[idx]) begin
                grant_any      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Completion side of the issue/scoreboard protocol. Buffers one finished
// result per functional unit, shares the single register-file write port
// round-robin, and releases the scoreboard pending bit of every retired
// instruction -- including ones whose register write is suppressed.
module writeback_arbiter
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
)
(
    input  logic                clock,
    input  logic                reset,
    input  logic [2:0]          fu_wb_valid,
    output logic [2:0]          fu_wb_ready,
    input  logic [3*REG_AW-1:0] fu_wb_regdest,
    input  logic [3*DATA_W-1:0] fu_wb_data,
    input  logic [2:0]          fu_wb_writereg,
    input  logic [2:0]          fu_wb_ov,
    input  logic [2:0]          fu_wb_writeov,
    output logic [REG_AW-1:0]   wb_reg_addr,
    output logic [DATA_W-1:0]   wb_reg_data,
    output logic                wb_reg_we,
    output logic                wb_sb_clr,
    output logic [REG_AW-1:0]   wb_sb_clr_addr,
    output logic [1:0]          wb_sb_clr_fu,
    output logic [CNT_W-1:0]    wb_retired_count
);
    import wb_pkg::*;

    // Holding-slot occupancy and round-robin pointer (control state)
    logic [2:0] full;
    logic [1:0] ptr;

    // Buffered results, one per unit; contents only matter while full
    slot_t slot_p0 [NUM_FU];
    slot_t incoming [NUM_FU];
    slot_t granted;

    logic [2:0] grant;
    logic [1:0] grant_idx;
    logic       grant_any;
    logic [2:0] accept;

    // A register write happens only for a real destination and when an
    // overflow, if any, is allowed to commit its result
    function automatic logic write_enable(input slot_t s);
        return s.writereg && (s.regdest != '0) && !(s.ov && !s.writeov);
    endfunction

    rr_arbiter3 u_arb (
        .request   (full),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // A slot can take a new result when empty or when it drains this cycle
    assign fu_wb_ready = ~full | grant;
    assign accept      = fu_wb_valid & fu_wb_ready;
    assign granted     = slot_p0[grant_idx];

    // Unpack the per-unit port slices into slot records
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            incoming[i]          = '0;
            incoming[i].regdest  = fu_wb_regdest[i*REG_AW +: REG_AW];
            incoming[i].data     = fu_wb_data[i*DATA_W +: DATA_W];
            incoming[i].writereg = fu_wb_writereg[i];
            incoming[i].ov       = fu_wb_ov[i];
            incoming[i].writeov  = fu_wb_writeov[i];
        end
    end

    // Track slot occupancy; a simultaneous drain and refill leaves it full
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full <= 3'b000;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (accept[i]) begin
                    full[i] <= 1'b1;
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    // Advance the round-robin pointer past the unit just granted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= 2'd0;
        end else if (grant_any) begin
            ptr <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
        end
    end

    // Capture an accepted result into its unit's holding slot
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                slot_p0[i] <= incoming[i];
            end
        end
    end

    // ---- stage p0 -> p1: register the granted entry onto the write port ----
    // Register-file write and scoreboard clear for the granted entry
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_reg_we      <= 1'b0;
            wb_sb_clr      <= 1'b0;
            wb_reg_addr    <= '0;
            wb_reg_data    <= '0;
            wb_sb_clr_addr <= '0;
            wb_sb_clr_fu   <= 2'b00;
        end else if (grant_any) begin
            wb_reg_we      <= write_enable(granted);
            wb_sb_clr      <= granted.writereg;
            wb_reg_addr    <= granted.regdest;
            wb_reg_data    <= granted.data;
            wb_sb_clr_addr <= granted.regdest;
            wb_sb_clr_fu   <= fu_code_of(grant_idx);
        end else begin
            wb_reg_we      <= 1'b0;
            wb_sb_clr      <= 1'b0;
        end
    end

    // Count every granted entry, whether or not it wrote a register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_retired_count <= '0;
        end else if (grant_any) begin
            wb_retired_count <= wb_retired_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed testbench for writeback_arbiter with a retirement scoreboard.
module tb_writeback_arbiter;

    logic        clock;
    logic        reset;
    logic [2:0]  valid;
    logic [2:0]  ready;
    logic [14:0] regdest;
    logic [95:0] data;
    logic [2:0]  writereg;
    logic [2:0]  ov;
    logic [2:0]  writeov;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        reg_we;
    logic        sb_clr;
    logic [4:0]  sb_clr_addr;
    logic [1:0]  sb_clr_fu;
    logic [31:0] retired_count;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        we;
        logic [1:0]  fu;
    } exp_t;

    exp_t        sb [$];
    int          tests;
    int          fails;
    logic [31:0] exp_count;

    writeback_arbiter #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .fu_wb_valid      (valid),
        .fu_wb_ready      (ready),
        .fu_wb_regdest    (regdest),
        .fu_wb_data       (data),
        .fu_wb_writereg   (writereg),
        .fu_wb_ov         (ov),
        .fu_wb_writeov    (writeov),
        .wb_reg_addr      (reg_addr),
        .wb_reg_data      (reg_data),
        .wb_reg_we        (reg_we),
        .wb_sb_clr        (sb_clr),
        .wb_sb_clr_addr   (sb_clr_addr),
        .wb_sb_clr_fu     (sb_clr_fu),
        .wb_retired_count (retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Load one unit's fields and record what its retirement must look like
    task automatic load_unit(input int u, input logic [4:0] rd, input logic [31:0] d,
                             input logic wr, input logic o, input logic wo);
        exp_t e;
        regdest[u*5 +: 5]  = rd;
        data[u*32 +: 32]   = d;
        writereg[u]        = wr;
        ov[u]              = o;
        writeov[u]         = wo;
        e.addr = rd;
        e.data = d;
        e.we   = wr && (rd != 5'd0) && !(o && !wo);
        e.fu   = 2'(u + 1);
        sb.push_back(e);
    endtask

    // Compare the current write-port outputs with the oldest expectation
    task automatic check_retire(input string tag);
        exp_t e;
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL %s_queue: observed %0d expected >0", tag, sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_count = exp_count + 32'd1;
            check({tag, "_clr"},      64'(sb_clr),        64'd1);
            check({tag, "_we"},       64'(reg_we),        64'(e.we));
            check({tag, "_addr"},     64'(reg_addr),      64'(e.addr));
            check({tag, "_data"},     64'(reg_data),      64'(e.data));
            check({tag, "_clr_addr"}, 64'(sb_clr_addr),   64'(e.addr));
            check({tag, "_clr_fu"},   64'(sb_clr_fu),     64'(e.fu));
            check({tag, "_count"},    64'(retired_count), 64'(exp_count));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_we"},  64'(reg_we), 64'd0);
        check({tag, "_clr"}, 64'(sb_clr), 64'd0);
    endtask

    initial begin
        tests = 0; fails = 0; exp_count = 32'd0;
        reset = 1'b0; valid = 3'b000; regdest = '0; data = '0;
        writereg = '0; ov = '0; writeov = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // Reset state
        check("rst_ready", 64'(ready), 64'h7);
        check_idle("rst");
        check("rst_addr",     64'(reg_addr),      64'd0);
        check("rst_data",     64'(reg_data),      64'd0);
        check("rst_clr_addr", 64'(sb_clr_addr),   64'd0);
        check("rst_clr_fu",   64'(sb_clr_fu),     64'd0);
        check("rst_count",    64'(retired_count), 64'd0);

        // All three units at once, pointer at ALU: ALU, MEM, MUL in order
        load_unit(0, 5'd1, 32'h0000_0011, 1'b1, 1'b0, 1'b0);
        load_unit(1, 5'd2, 32'h0000_0022, 1'b1, 1'b0, 1'b0);
        load_unit(2, 5'd3, 32'h0000_0033, 1'b1, 1'b0, 1'b0);
        valid = 3'b111;
        step(); valid = 3'b000;
        check("all3_ready0", 64'(ready), 64'h1);
        step(); check_retire("all3_alu");
        check("all3_ready1", 64'(ready), 64'h3);
        step(); check_retire("all3_mem");
        check("all3_ready2", 64'(ready), 64'h7);
        step(); check_retire("all3_mul");
        step(); check_idle("all3_after");

        // Pointer wrapped to ALU: ALU wins over MEM
        load_unit(0, 5'd4, 32'h0000_0044, 1'b1, 1'b0, 1'b0);
        load_unit(1, 5'd6, 32'h0000_0066, 1'b1, 1'b0, 1'b0);
        valid = 3'b011;
        step(); valid = 3'b000;
        step(); check_retire("wrap_alu");
        step(); check_retire("wrap_mem");

        // Single ALU result: pulses appear one cycle after acceptance
        load_unit(0, 5'd5, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
        valid = 3'b001;
        step(); valid = 3'b000;
        check_idle("alu1_early");
        step(); check_retire("alu1");
        step(); check_idle("alu1_after");

        // MUL overflow without writeov: no write, clear still issued
        load_unit(2, 5'd9, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
        valid = 3'b100;
        step(); valid = 3'b000;
        step(); check_retire("mul_ov");

        // ALU write to r0: suppressed write, clear still issued
        load_unit(0, 5'd0, 32'h0000_0055, 1'b1, 1'b0, 1'b0);
        valid = 3'b001;
        step(); valid = 3'b000;
        step(); check_retire("alu_r0");

        // Four back-to-back ALU results with ready held high
        for (int k = 0; k < 4; k++) begin
            load_unit(0, 5'(10 + k), 32'h0000_5000 + 32'(k), 1'b1, 1'b0, 1'b0);
            valid = 3'b001;
            check($sformatf("b2b_ready%0d", k), 64'(ready[0]), 64'd1);
            step();
            if (k >= 1) check_retire($sformatf("b2b_%0d", k - 1));
        end
        valid = 3'b000;
        step(); check_retire("b2b_3");

        // Buffered entries discarded by an asynchronous mid-cycle reset
        regdest[4:0] = 5'd7;  data[31:0]  = 32'h77; writereg[0] = 1'b1;
        regdest[9:5] = 5'd8;  data[63:32] = 32'h88; writereg[1] = 1'b1;
        valid = 3'b011;
        step(); valid = 3'b000;
        #2 reset = 1'b0;
        #1;
        check_idle("arst");
        check("arst_addr",     64'(reg_addr),      64'd0);
        check("arst_data",     64'(reg_data),      64'd0);
        check("arst_clr_addr", 64'(sb_clr_addr),   64'd0);
        check("arst_clr_fu",   64'(sb_clr_fu),     64'd0);
        check("arst_count",    64'(retired_count), 64'd0);
        step(); step();
        reset = 1'b1;
        check("arst_ready", 64'(ready), 64'h7);
        for (int k = 0; k < 3; k++) begin
            step();
            check_idle($sformatf("arst_quiet%0d", k));
        end
        check("arst_count_after", 64'(retired_count), 64'd0);
        check("arst_queue_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
